uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver: the receive-side counterpart of uart_tx in the FPGA UART examples.
//   Input: asynchronous serial line RXD. Output: one byte per frame with a 1-cycle valid strobe.
//   Flags frames whose stop bit is bad. Can be looped back onto uart_tx for board tests.
// PARAMETERS
//   FREQ  50_000_000  clock frequency, Hz
//   RATE  2_000_000   baud rate, bit/s
//   (derived) DIV = FREQ/RATE, integer division, clocks per bit. HALF = DIV/2.
//   Elaboration must fail if DIV < 4.
// PORTS
//   clk     in   1  system clock; the only clock
//   rst     in   1  asynchronous, active-high reset
//   i_rx    in   1  serial line, asynchronous to clk; idle level is 1
//   o_data  out  8  last received byte, LSB received first; held until the next good frame
//   o_vld   out  1  1-cycle pulse: o_data updated with a good frame
//   o_err   out  1  1-cycle pulse: framing error (stop bit sampled 0)
//   o_busy  out  1  high while the FSM is in any state other than IDLE
// BEHAVIOUR
//   Reset (async, rst=1): all outputs 0, FSM=IDLE, counters 0.
//     Both synchronizer flops and the edge-history flop are preset to 1.
//     Reset mid-frame aborts the frame: no vld/err pulse; after release the FSM waits for a fresh falling edge.
//   Sync: i_rx passes through a 2-flop synchronizer to give rx_s. rx_p = rx_s delayed 1 cycle.
//   IDLE: start when rx_p==1 && rx_s==0 (falling edge). Load the bit counter and go to START.
//     Call this cycle t0.
//     A line held low never retriggers; a new 1->0 edge is required.
//   START: sample rx_s at t0+HALF.
//     0 -> go to DATA.
//     1 -> glitch: return to IDLE, no output.
//   DATA: sample bit k (k=0..7) at t0+HALF+(k+1)*DIV. Shift into a register, LSB first.
//     After bit 7, go to STOP.
//   STOP: sample at t0+HALF+9*DIV.
//     1 -> o_data<=shift reg and o_vld=1 in the next cycle.
//     0 -> o_err=1 in the next cycle; o_data unchanged.
//     In both cases FSM=IDLE in that same next cycle, so a start edge arriving right after the stop bit is caught.
//   o_vld and o_err are never high together and are never high for 2 consecutive cycles.
//   Latency: o_vld at t0+HALF+9*DIV+1. t0 itself is 2-3 clocks after the i_rx edge (synchronizer).
//   Bit counter: counts to DIV-1 and wraps to 0. No accumulated drift: each sample is exactly DIV after the previous one.
//   Tolerance: the receiver is only guaranteed for a sender baud within +/-2% of RATE.
// TESTING  (FREQ=50e6, RATE=2e6, DIV=25, HALF=12; bench drives i_rx in 25-clock bits)
//   1. Frame 0x35 (start,1,0,1,0,1,1,0,0,stop) -> exactly one o_vld pulse at t0+238, o_data=8'h35, o_err never high.
//   2. Back-to-back frames 0x00 then 0xFF, 1 stop bit each, no gap -> two o_vld pulses 250 clocks apart; o_data 8'h00 then 8'hFF.
//   3. i_rx low for 5 clocks, then high -> o_busy high for ~12 clocks then low; no o_vld, no o_err.
//   4. Frame 0xA5 with stop=0, line then held 0 for 500 clocks -> one o_err pulse, o_data keeps its previous value, no retrigger until a 1->0 edge.
//   5. rst pulsed at data bit 4 of a frame, the rest of the frame still driven -> no pulses; the next clean frame 0x5A is received correctly.
//   6. Loopback through uart_tx sending 0x30..0x3F -> 16 o_vld pulses with matching o_data; repeat with bench baud at +/-2% -> same result.

Source files
------------

// File: rtl/uart_rx_if.sv
// Serial receive bundle: line input plus byte/status outputs.
// The receiver takes the slave side; the line driver takes the master side.
interface uart_rx_if;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_vld;
    logic       o_err;
    logic       o_busy;

    modport master (
        output i_rx,
        input  o_data,
        input  o_vld,
        input  o_err,
        input  o_busy
    );

    modport slave (
        input  i_rx,
        output o_data,
        output o_vld,
        output o_err,
        output o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect,
// mid-bit sampling on a fixed DIV grid, framing-error flag on a bad stop bit.
module uart_rx #(
    parameter int FREQ = 50_000_000,
    parameter int RATE = 2_000_000
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int DIV  = FREQ / RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 2;

    generate
        if (DIV < 4) begin : g_div_chk
            $error("uart_rx: FREQ/RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_p;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic [7:0]    data;
    logic          vld;
    logic          err;
    logic          busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_p    <= 1'b1;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data    <= '0;
            vld     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rx_meta <= bus.i_rx;
            rx_s    <= rx_meta;
            rx_p    <= rx_s;
            vld     <= 1'b0;
            err     <= 1'b0;
            // free-running grid: every sample lands exactly DIV after the last
            if (cnt == CW'(DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_p && !rx_s) begin
                        state <= START;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CW'(HALF)) begin
                        cnt <= CW'(1);
                        idx <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rx_s, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (rx_s) begin
                            data <= shreg;
                            vld  <= 1'b1;
                        end else begin
                            err  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_data = data;
    assign bus.o_vld  = vld;
    assign bus.o_err  = err;
    assign bus.o_busy = busy;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level model predicts each pulse at
// edge+2+HALF+9*DIV+1 and the held byte; checked on every negedge.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    uart_rx_if bus();

    uart_rx #(
        .FREQ(50_000_000),
        .RATE(2_000_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        int         at;
        bit         is_err;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         vld_cyc[$];
    int         err_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_data = 8'h00;
    bit         ev;
    bit         ee;
    logic [7:0] ed;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_data = 8'h00;
            chk("rst_vld", 32'(bus.o_vld), 32'd0);
            chk("rst_err", 32'(bus.o_err), 32'd0);
            chk("rst_data", 32'(bus.o_data), 32'd0);
        end else begin
            ev = 1'b0;
            ee = 1'b0;
            ed = 8'h00;
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL event_due: cycle %0d passed, now %0d",
                         exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                ev = !exp_q[0].is_err;
                ee = exp_q[0].is_err;
                ed = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            if (ev) model_data = ed;
            chk("vld", 32'(bus.o_vld), 32'(ev));
            chk("err", 32'(bus.o_err), 32'(ee));
            chk("data", 32'(bus.o_data), 32'(model_data));
            if (bus.o_vld) vld_cyc.push_back(cyc);
            if (bus.o_err) err_cnt++;
        end
    end

    // per = bit period in milli-clocks; frame = start, 8 data LSB first, stop
    task automatic send(input logic [7:0] b, input bit stop,
                        input int per, input bit expect_it,
                        output int n);
        logic [9:0] fr;
        int len;
        fr  = {stop, b, 1'b0};
        len = (10 * per + 999) / 1000;
        n   = 0;
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            bus.i_rx = fr[(c * 1000) / per];
            if (c == 0) begin
                n = cyc;
                if (expect_it) exp_q.push_back('{n + 240, !stop, b});
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            bus.i_rx = 1'b1;
        end
    endtask

    task automatic clear();
        vld_cyc.delete();
        err_cnt = 0;
    endtask

    int n;
    int n2;
    int busy_n;
    int pers[3] = '{25000, 25500, 24500};

    initial begin
        bus.i_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_data", 32'(bus.o_data), 32'h00);
        chk("reset_vld", 32'(bus.o_vld), 32'd0);
        chk("reset_err", 32'(bus.o_err), 32'd0);
        chk("reset_busy", 32'(bus.o_busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(10);

        clear();
        send(8'h35, 1'b1, 25000, 1'b1, n);
        idle(20);
        chk("t1_count", 32'(vld_cyc.size()), 32'd1);
        if (vld_cyc.size() > 0)
            chk("t1_latency", 32'(vld_cyc[0] - n), 32'd240);
        chk("t1_data", 32'(bus.o_data), 32'h35);
        chk("t1_err", 32'(err_cnt), 32'd0);

        clear();
        send(8'h00, 1'b1, 25000, 1'b1, n);
        chk("t2_first", 32'(bus.o_data), 32'h00);
        send(8'hFF, 1'b1, 25000, 1'b1, n2);
        idle(20);
        chk("t2_count", 32'(vld_cyc.size()), 32'd2);
        if (vld_cyc.size() > 1)
            chk("t2_gap", 32'(vld_cyc[1] - vld_cyc[0]), 32'd250);
        chk("t2_data", 32'(bus.o_data), 32'hFF);

        clear();
        busy_n = 0;
        fork
            begin
                @(posedge clk);
                #1 bus.i_rx = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.i_rx = 1'b1;
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (bus.o_busy) busy_n++;
                end
            end
        join
        chk("t3_busy_cycles", 32'(busy_n), 32'd12);
        chk("t3_vld", 32'(vld_cyc.size()), 32'd0);
        chk("t3_err", 32'(err_cnt), 32'd0);
        idle(10);

        clear();
        send(8'hA5, 1'b0, 25000, 1'b1, n);
        repeat (500) begin
            @(posedge clk);
            #1 bus.i_rx = 1'b0;
        end
        chk("t4_err", 32'(err_cnt), 32'd1);
        chk("t4_vld", 32'(vld_cyc.size()), 32'd0);
        chk("t4_data_held", 32'(bus.o_data), 32'hFF);
        chk("t4_busy", 32'(bus.o_busy), 32'd0);
        idle(60);
        chk("t4_no_retrig", 32'(err_cnt), 32'd1);

        clear();
        fork
            send(8'hF3, 1'b1, 25000, 1'b0, n);
            begin
                repeat (131) @(posedge clk);
                #1 rst = 1'b1;
                repeat (4) @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        chk("t5_busy", 32'(bus.o_busy), 32'd0);
        idle(300);
        chk("t5_vld", 32'(vld_cyc.size()), 32'd0);
        chk("t5_err", 32'(err_cnt), 32'd0);
        chk("t5_data_rst", 32'(bus.o_data), 32'h00);
        send(8'h5A, 1'b1, 25000, 1'b1, n);
        idle(20);
        chk("t5_count", 32'(vld_cyc.size()), 32'd1);
        chk("t5_data", 32'(bus.o_data), 32'h5A);

        foreach (pers[p]) begin
            clear();
            for (int b = 8'h30; b <= 8'h3F; b++)
                send(8'(b), 1'b1, pers[p], 1'b1, n);
            idle(20);
            chk("t6_count", 32'(vld_cyc.size()), 32'd16);
            chk("t6_last", 32'(bus.o_data), 32'h3F);
            chk("t6_err", 32'(err_cnt), 32'd0);
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
